// File: rtl/cpu0_pkg.sv
// Shared definitions for the CPU0 fetch path: opcodes, fetch FSM states and fault codes.
package cpu0_pkg;

  localparam logic [7:0] LD  = 8'h00;
  localparam logic [7:0] ST  = 8'h01;
  localparam logic [7:0] ADD = 8'h13;
  localparam logic [7:0] JMP = 8'h26;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;

  // Instructions are word-sized, so a legal fetch address has its two low bits clear.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/cpu0_ir_decode.sv
// Combinational field slicing of a CPU0 instruction word; shared by fetch and control.
module cpu0_ir_decode (
  input  logic [31:0] ir,
  output logic [7:0]  op,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic [11:0] cx12,
  output logic [15:0] cx16,
  output logic [23:0] cx24
);

  assign op   = ir[31:24];
  assign ra   = ir[23:20];
  assign rb   = ir[19:16];
  assign rc   = ir[15:12];
  assign cx12 = ir[11:0];
  assign cx16 = ir[15:0];
  assign cx24 = ir[23:0];

endmodule

// File: rtl/cpu0_fetch_unit.sv
// Multicycle CPU0 fetch stage: handshaked memory read, instruction register, redirect and watchdog.
// Optional misaligned-redirect/reset-PC fault enabled by defining CPU0_FETCH_ALIGN_CHK_EN.
module cpu0_fetch_unit
  import cpu0_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             TIMEOUT  = 16,
  parameter int             CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic [AW-1:0]     abus,
  output logic              m_en,
  output logic              m_rw,
  input  logic [DW-1:0]     dbus,
  input  logic              m_ack,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DW-1:0]     ir,
  output logic [7:0]        op,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [3:0]        rc,
  output logic [11:0]       cx12,
  output logic [15:0]       cx16,
  output logic [23:0]       cx24,
  output logic [AW-1:0]     pc,
  input  logic              br_valid,
  input  logic [AW-1:0]     br_target,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  instr_cnt,
  output fetch_state_t      fsm_state
);

  // Handshake: memory read completes in a cycle with m_en=1 and m_ack=1;
  // execute takes ir in a cycle with ir_valid=1 and ir_ready=1.

`ifdef CPU0_FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  fetch_state_t   state;
  logic [WCW-1:0] wcnt;

  assign abus      = pc;
  assign m_rw      = 1'b1;
  assign m_en      = (state == FETCH) && !reset;
  assign ir_valid  = (state == HOLD) && !reset;
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      state     <= FETCH;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      instr_cnt <= '0;
      wcnt      <= '0;
      if (ALIGN_CHK && !is_aligned(RESET_PC[1:0])) begin
        state    <= ERR;
        err      <= 1'b1;
        err_code <= ERR_ALIGN;
      end
    end else begin
      case (state)
        FETCH: begin
          // A redirect wins over a completing read; the fetched word is dropped.
          if (br_valid) begin
            pc   <= br_target;
            wcnt <= '0;
            if (ALIGN_CHK && !is_aligned(br_target[1:0])) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= ERR_ALIGN;
            end else begin
              state <= FETCH;
            end
          end else if (m_ack) begin
            ir    <= dbus;
            state <= HOLD;
            wcnt  <= '0;
          end else if (wcnt == WAIT_LAST) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        HOLD: begin
          // The hand-off counts even when a redirect replaces the sequential PC.
          if (ir_ready) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
          end
          if (br_valid) begin
            pc   <= br_target;
            wcnt <= '0;
            if (ALIGN_CHK && !is_aligned(br_target[1:0])) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= ERR_ALIGN;
            end else begin
              state <= FETCH;
            end
          end else if (ir_ready) begin
            pc    <= pc + AW'(4);
            wcnt  <= '0;
            state <= FETCH;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= FETCH;
          wcnt  <= '0;
        end
      endcase
    end
  end

  cpu0_ir_decode u_decode (
    .ir   (ir[31:0]),
    .op   (op),
    .ra   (ra),
    .rb   (rb),
    .rc   (rc),
    .cx12 (cx12),
    .cx16 (cx16),
    .cx24 (cx24)
  );

endmodule
